// File: rtl/usb_mon_pkg.sv
// Shared line-state types, event record layout and register map for usb_line_monitor.
package usb_mon_pkg;

    localparam int unsigned TS_W      = 16;
    localparam int unsigned SE0_CNT_W = 16;
    localparam int unsigned DG_W      = 4;

    typedef enum logic [1:0] {
        LS_SE0 = 2'd0,
        LS_K   = 2'd1,
        LS_J   = 2'd2,
        LS_SE1 = 2'd3
    } line_state_t;

    typedef struct packed {
        logic [TS_W-1:0] timestamp;
        logic [7:0]      channel;
        logic [3:0]      zero;
        line_state_t     prev_state;
        line_state_t     new_state;
    } event_rec_t;

    localparam logic [1:0] REG_STATUS    = 2'd0;
    localparam logic [1:0] REG_EVENT     = 2'd1;
    localparam logic [1:0] REG_CTRL      = 2'd2;
    localparam logic [1:0] REG_TIMESTAMP = 2'd3;

    localparam int unsigned CTRL_ENABLE_BIT = 0;
    localparam int unsigned CTRL_CLEAR_BIT  = 1;

    // {d_p,d_n} already matches the state encoding: 10=J, 01=K, 00=SE0, 11=SE1.
    function automatic line_state_t decode_line(input logic d_p, input logic d_n);
        return line_state_t'({d_p, d_n});
    endfunction

endpackage

// File: rtl/usb_mon_fifo.sv
// Synchronous FIFO for event records; flush empties it, simultaneous push+pop on full succeeds.
module usb_mon_fifo #(
    parameter int unsigned DEPTH = 16,
    parameter int unsigned WIDTH = 32,
    localparam int unsigned AW   = $clog2(DEPTH),
    localparam int unsigned LW   = AW + 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             flush,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] head_c,
    output logic             full,
    output logic             empty,
    output logic [LW-1:0]    level
);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [LW-1:0]    count;
    logic             do_push;
    logic             do_pop;

    assign empty   = (count == '0);
    assign full    = (count == LW'(DEPTH));
    assign level   = count;
    assign head_c  = mem[rd_ptr];
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);

    always_ff @(posedge clk) begin
        if (!reset || flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + AW'(1);
            if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
            count <= count + LW'(do_push) - LW'(do_pop);
        end
    end

    always_ff @(posedge clk) begin
        if (do_push && !flush) mem[wr_ptr] <= push_data;
    end

endmodule

// File: rtl/usb_line_monitor.sv
// Multi-channel USB FS line monitor: deglitched J/K/SE0/SE1 change log, bus-reset detect, Wishbone slave.
// Define USB_MON_TIMESTAMP_EN to build the 16-bit event timestamp counter.
module usb_line_monitor
    import usb_mon_pkg::*;
#(
    parameter int unsigned CHANNELS         = 1,
    parameter int unsigned FIFO_DEPTH       = 16,
    parameter int unsigned DEGLITCH         = 2,
    parameter int unsigned SE0_RESET_CYCLES = 120
) (
    input  logic                clk48,
    input  logic                reset,
    input  logic [CHANNELS-1:0] usb_d_p,
    input  logic [CHANNELS-1:0] usb_d_n,
    input  logic [29:0]         wishbone_adr,
    input  logic [31:0]         wishbone_datwr,
    output logic [31:0]         wishbone_datrd,
    input  logic [3:0]          wishbone_sel,
    input  logic                wishbone_cyc,
    input  logic                wishbone_stb,
    input  logic                wishbone_we,
    output logic                wishbone_ack,
    output logic                wishbone_err,
    output logic [CHANNELS-1:0] bus_reset
);

    localparam int unsigned LW = $clog2(FIFO_DEPTH) + 1;
    localparam logic [DG_W-1:0]      DG_MAX  = DG_W'(DEGLITCH);
    localparam logic [SE0_CNT_W-1:0] SE0_MAX = SE0_CNT_W'(SE0_RESET_CYCLES);

    logic                     enable_q;
    logic                     overflow_q;
    logic [TS_W-1:0]          ts_q;
    logic [CHANNELS-1:0]      pend_valid;
    logic [CHANNELS-1:0][31:0] pend_rec;
    logic [CHANNELS-1:0]      drop_c;
    logic [CHANNELS-1:0]      sticky;
    logic [CHANNELS-1:0]      grant_c;
    logic [31:0]              push_data_c;
    logic                     push_c;
    logic [31:0]              head_c;
    logic                     fifo_full;
    logic                     fifo_empty;
    logic [LW-1:0]            fifo_level;
    logic                     acc_c;
    logic                     adr_ok_c;
    logic                     rd_c;
    logic                     wr_c;
    logic                     pop_c;
    logic                     clear_c;
    logic [31:0]              rdata_c;
    logic                     unused_c;

    assign unused_c = ^{wishbone_sel, wishbone_datwr[31:2]};

    // Wishbone access decode; a new access is only taken once the previous ack/err has retired.
    assign acc_c    = wishbone_cyc && wishbone_stb && !wishbone_ack && !wishbone_err;
    assign adr_ok_c = (wishbone_adr[29:2] == '0);
    assign rd_c     = acc_c && adr_ok_c && !wishbone_we;
    assign wr_c     = acc_c && adr_ok_c && wishbone_we;
    assign pop_c    = rd_c && (wishbone_adr[1:0] == REG_EVENT) && !fifo_empty;
    assign clear_c  = wr_c && (wishbone_adr[1:0] == REG_CTRL) && wishbone_datwr[CTRL_CLEAR_BIT];

`ifdef USB_MON_TIMESTAMP_EN
    always_ff @(posedge clk48) begin
        if (!reset || clear_c) ts_q <= '0;
        else                   ts_q <= ts_q + TS_W'(1);
    end
`else
    assign ts_q = '0;
`endif

    for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
        logic            dp_s1, dp_s2, dn_s1, dn_s2;
        line_state_t     last_q, committed_q, prev_q, dec_c;
        logic [DG_W-1:0] hold_q, hold_c;
        logic            chg_q;
        logic [SE0_CNT_W-1:0] se0_cnt;
        logic            bus_rst_q;
        logic            sticky_q;
        logic            pend_v;
        event_rec_t      pend_q;
        event_rec_t      rec_c;
        logic            load_c;

        assign dec_c  = decode_line(dp_s2, dn_s2);
        assign hold_c = (dec_c != last_q) ? DG_W'(1) :
                        (hold_q == DG_MAX) ? DG_MAX : hold_q + DG_W'(1);

        // Synchronizer, decode and deglitch; commit once the candidate held DEGLITCH cycles.
        always_ff @(posedge clk48) begin
            if (!reset) begin
                dp_s1       <= 1'b0;
                dp_s2       <= 1'b0;
                dn_s1       <= 1'b0;
                dn_s2       <= 1'b0;
                last_q      <= LS_SE0;
                committed_q <= LS_SE0;
                prev_q      <= LS_SE0;
                hold_q      <= '0;
                chg_q       <= 1'b0;
            end else begin
                dp_s1  <= usb_d_p[i];
                dp_s2  <= dp_s1;
                dn_s1  <= usb_d_n[i];
                dn_s2  <= dn_s1;
                last_q <= dec_c;
                hold_q <= hold_c;
                chg_q  <= 1'b0;
                if (hold_c == DG_MAX && dec_c != committed_q) begin
                    committed_q <= dec_c;
                    prev_q      <= committed_q;
                    chg_q       <= 1'b1;
                end
            end
        end

        // SE0 run counter saturates at the reset threshold; sticky latches on arrival.
        always_ff @(posedge clk48) begin
            if (!reset) begin
                se0_cnt   <= '0;
                bus_rst_q <= 1'b0;
                sticky_q  <= 1'b0;
            end else begin
                if (clear_c) sticky_q <= 1'b0;
                if (!enable_q || committed_q != LS_SE0) begin
                    se0_cnt   <= '0;
                    bus_rst_q <= 1'b0;
                end else if (se0_cnt != SE0_MAX) begin
                    se0_cnt   <= se0_cnt + SE0_CNT_W'(1);
                    bus_rst_q <= (se0_cnt + SE0_CNT_W'(1) == SE0_MAX);
                    if (se0_cnt + SE0_CNT_W'(1) == SE0_MAX && !clear_c) sticky_q <= 1'b1;
                end
            end
        end

        assign rec_c = '{timestamp: ts_q, channel: 8'(i), zero: 4'h0,
                         prev_state: prev_q, new_state: committed_q};
        assign load_c = chg_q && enable_q && (!pend_v || grant_c[i]);

        always_ff @(posedge clk48) begin
            if (!reset || clear_c) pend_v <= 1'b0;
            else if (load_c)       pend_v <= 1'b1;
            else if (grant_c[i])   pend_v <= 1'b0;
        end

        always_ff @(posedge clk48) begin
            if (load_c) pend_q <= rec_c;
        end

        assign pend_valid[i] = pend_v;
        assign pend_rec[i]   = pend_q;
        assign drop_c[i]     = chg_q && enable_q && pend_v && !grant_c[i] && !clear_c;
        assign sticky[i]     = sticky_q;
        assign bus_reset[i]  = bus_rst_q;
    end

    // Fixed priority: lowest channel with a pending record wins.
    assign grant_c = pend_valid & (~pend_valid + CHANNELS'(1));
    assign push_c  = (|pend_valid) && !clear_c;

    always_comb begin
        push_data_c = '0;
        for (int unsigned i = 0; i < CHANNELS; i++) begin
            if (grant_c[i]) push_data_c = pend_rec[i];
        end
    end

    usb_mon_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (32)
    ) u_fifo (
        .clk       (clk48),
        .reset     (reset),
        .flush     (clear_c),
        .push      (push_c),
        .push_data (push_data_c),
        .pop       (pop_c),
        .head_c    (head_c),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .level     (fifo_level)
    );

    always_comb begin
        rdata_c = '0;
        case (wishbone_adr[1:0])
            REG_STATUS:    rdata_c = {overflow_q, 6'd0, 9'(fifo_level), 16'(sticky)};
            REG_EVENT:     rdata_c = fifo_empty ? 32'hFFFF_FFFF : head_c;
            REG_CTRL:      rdata_c = {31'd0, enable_q};
            REG_TIMESTAMP: rdata_c = {16'd0, ts_q};
            default:       rdata_c = '0;
        endcase
    end

    always_ff @(posedge clk48) begin
        if (!reset) begin
            wishbone_ack   <= 1'b0;
            wishbone_err   <= 1'b0;
            wishbone_datrd <= '0;
            enable_q       <= 1'b0;
            overflow_q     <= 1'b0;
        end else begin
            wishbone_ack   <= acc_c && adr_ok_c;
            wishbone_err   <= acc_c && !adr_ok_c;
            wishbone_datrd <= rd_c ? rdata_c : 32'd0;
            if (wr_c && wishbone_adr[1:0] == REG_CTRL) enable_q <= wishbone_datwr[CTRL_ENABLE_BIT];
            if (clear_c)
                overflow_q <= 1'b0;
            else if ((push_c && fifo_full && !pop_c) || (|drop_c))
                overflow_q <= 1'b1;
        end
    end

endmodule

// File: tb/tb_usb_line_monitor.sv
// Scoreboard bench for usb_line_monitor: expected Wishbone responses are queued, a monitor checks them on ack/err.
module tb_usb_line_monitor;

    localparam int unsigned CH = 4;
    localparam int unsigned FD = 4;
    localparam logic [1:0] LS_SE0_V = 2'b00;
    localparam logic [1:0] LS_K_V   = 2'b01;
    localparam logic [1:0] LS_J_V   = 2'b10;
`ifdef USB_MON_TIMESTAMP_EN
    localparam logic [31:0] EVM = 32'h0000_FFFF;
    localparam logic [31:0] TSM = 32'hFFFF_0000;
`else
    localparam logic [31:0] EVM = 32'hFFFF_FFFF;
    localparam logic [31:0] TSM = 32'hFFFF_FFFF;
`endif

    logic          clk48 = 1'b0;
    logic          reset;
    logic [CH-1:0] dp, dn;
    logic [29:0]   adr;
    logic [31:0]   datwr, datrd;
    logic [3:0]    sel;
    logic          cyc, stb, we, ack, err;
    logic [CH-1:0] bus_reset;

    always #5 clk48 = ~clk48;

    usb_line_monitor #(
        .CHANNELS(CH), .FIFO_DEPTH(FD), .DEGLITCH(2), .SE0_RESET_CYCLES(120)
    ) dut (
        .clk48(clk48), .reset(reset), .usb_d_p(dp), .usb_d_n(dn),
        .wishbone_adr(adr), .wishbone_datwr(datwr), .wishbone_datrd(datrd),
        .wishbone_sel(sel), .wishbone_cyc(cyc), .wishbone_stb(stb), .wishbone_we(we),
        .wishbone_ack(ack), .wishbone_err(err), .bus_reset(bus_reset)
    );

    typedef struct {
        logic [31:0] data;
        logic [31:0] mask;
        logic        is_err;
        string       name;
    } exp_t;

    exp_t        exp_q[$];
    logic [31:0] ev_log[$];
    int          n_cmp = 0;
    int          n_bad = 0;

    // Monitor: every ack/err pops one expectation.
    always @(negedge clk48) begin
        exp_t e;
        if (ack || err) begin
            n_cmp++;
            if (exp_q.size() == 0) begin
                n_bad++;
                $display("FAIL unexpected_response: ack=%b err=%b data=%h", ack, err, datrd);
            end else begin
                e = exp_q.pop_front();
                if (err !== e.is_err || ack !== !e.is_err || (datrd & e.mask) !== (e.data & e.mask)) begin
                    n_bad++;
                    $display("FAIL %s: got ack=%b err=%b data=%h, want err=%b data=%h (mask %h)",
                             e.name, ack, err, datrd, e.is_err, e.data, e.mask);
                end
                ev_log.push_back(datrd);
            end
        end
    end

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
        n_cmp++;
        if (got !== want) begin
            n_bad++;
            $display("FAIL %s: got %h want %h", name, got, want);
        end
    endtask

    task automatic wb(input logic w, input logic [29:0] a, input logic [31:0] wd,
                      input logic [31:0] exp_d, input logic [31:0] m, input logic e, input string name);
        exp_t x;
        x.data = exp_d; x.mask = m; x.is_err = e; x.name = name;
        exp_q.push_back(x);
        @(posedge clk48); #1;
        cyc = 1'b1; stb = 1'b1; we = w; adr = a; datwr = wd;
        for (int i = 0; i < 8; i++) begin
            @(posedge clk48); #1;
            if (ack || err) break;
        end
        if (!(ack || err)) begin
            n_cmp++; n_bad++;
            $display("FAIL %s: no ack or err within 8 cycles", name);
            void'(exp_q.pop_back());
        end
        cyc = 1'b0; stb = 1'b0; we = 1'b0;
    endtask

    task automatic rd(input logic [29:0] a, input logic [31:0] exp_d, input logic [31:0] m, input string name);
        wb(1'b0, a, 32'd0, exp_d, m, 1'b0, name);
    endtask

    task automatic wr(input logic [29:0] a, input logic [31:0] d, input string name);
        wb(1'b1, a, d, 32'd0, 32'd0, 1'b0, name);
    endtask

    task automatic cyc_wait(input int n);
        repeat (n) @(posedge clk48);
        #1;
    endtask

    task automatic set_ch(input int c, input logic [1:0] s);
        dp[c] = s[1];
        dn[c] = s[0];
    endtask

    initial begin
        #200_000;
        $display("FAIL global_timeout: bench did not finish");
        $fatal(1);
    end

    initial begin
        reset = 1'b0; dp = '0; dn = '0; adr = '0; datwr = '0; sel = 4'hF;
        cyc = 1'b0; stb = 1'b0; we = 1'b0;
        cyc_wait(4);
        check("rst_ack", 32'(ack), 32'd0);
        check("rst_datrd", datrd, 32'd0);
        check("rst_bus_reset", 32'(bus_reset), 32'd0);
        reset = 1'b1;

        rd(30'd0, 32'h0000_0000, 32'hFFFF_FFFF, "status_after_reset");
        rd(30'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, "event_empty_after_reset");

        // Park channels 1..3 on J while disabled: no records expected.
        for (int c = 1; c < CH; c++) set_ch(c, LS_J_V);
        cyc_wait(10);
        rd(30'd0, 32'h0000_0000, 32'hFFFF_FFFF, "status_disabled");
        wr(30'd2, 32'h1, "ctrl_enable");
        rd(30'd2, 32'h0000_0001, 32'hFFFF_FFFF, "ctrl_readback");

        // J then K on channel 0.
        set_ch(0, LS_J_V); cyc_wait(10);
        set_ch(0, LS_K_V); cyc_wait(10);
        rd(30'd0, 32'h0002_0000, 32'hFFFF_FFFF, "status_two_events");
        ev_log.delete();
        rd(30'd1, 32'h0000_0002, EVM, "event_se0_to_j");
        rd(30'd1, 32'h0000_0009, EVM, "event_j_to_k");
        rd(30'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, "event_empty_after_pops");
        cyc_wait(1);
`ifdef USB_MON_TIMESTAMP_EN
        check("timestamp_delta", 32'(ev_log[1][31:16] - ev_log[0][31:16]), 32'd10);
`endif

        // One-cycle K glitch during J must be filtered.
        set_ch(0, LS_J_V); cyc_wait(10);
        rd(30'd1, 32'h0000_0006, EVM, "event_k_to_j");
        set_ch(0, LS_K_V); cyc_wait(1);
        set_ch(0, LS_J_V); cyc_wait(10);
        rd(30'd0, 32'h0000_0000, 32'hFFFF_FFFF, "status_after_glitch");

        // Bus reset on channel 2.
        set_ch(2, LS_SE0_V); cyc_wait(100);
        check("bus_reset_early", 32'(bus_reset), 32'd0);
        for (int i = 0; i < 60; i++) begin
            if (bus_reset[2]) break;
            cyc_wait(1);
        end
        check("bus_reset_rise", 32'(bus_reset), 32'h4);
        rd(30'd0, 32'h0001_0004, 32'hFFFF_FFFF, "status_sticky");
        set_ch(2, LS_J_V);
        for (int i = 0; i < 20; i++) begin
            if (!bus_reset[2]) break;
            cyc_wait(1);
        end
        check("bus_reset_fall", 32'(bus_reset), 32'd0);
        cyc_wait(10);
        rd(30'd0, 32'h0002_0004, 32'hFFFF_FFFF, "status_sticky_held");
        rd(30'd1, 32'h0000_0208, EVM, "event_ch2_j_to_se0");
        rd(30'd1, 32'h0000_0202, EVM, "event_ch2_se0_to_j");
        wr(30'd2, 32'h3, "ctrl_clear");
        rd(30'd0, 32'h0000_0000, 32'hFFFF_FFFF, "status_after_clear");
        rd(30'd2, 32'h0000_0001, 32'hFFFF_FFFF, "ctrl_clear_reads_0");

        // Six changes into a 4-deep FIFO.
        for (int k = 0; k < 6; k++) begin
            set_ch(0, (k % 2 == 0) ? LS_K_V : LS_J_V);
            cyc_wait(8);
        end
        rd(30'd0, 32'h8004_0000, 32'hFFFF_FFFF, "status_overflow");
        rd(30'd1, 32'h0000_0009, EVM, "ovf_event0");
        rd(30'd1, 32'h0000_0006, EVM, "ovf_event1");
        rd(30'd1, 32'h0000_0009, EVM, "ovf_event2");
        rd(30'd1, 32'h0000_0006, EVM, "ovf_event3");
        rd(30'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, "ovf_empty");
        wr(30'd2, 32'h3, "ctrl_clear2");
        rd(30'd0, 32'h0000_0000, 32'hFFFF_FFFF, "status_after_clear2");

        // Channels 0 and 1 change together: channel 0 first.
        set_ch(0, LS_K_V); set_ch(1, LS_K_V); cyc_wait(10);
        rd(30'd0, 32'h0002_0000, 32'hFFFF_FFFF, "status_simul");
        rd(30'd1, 32'h0000_0009, EVM, "simul_ch0");
        rd(30'd1, 32'h0000_0109, EVM, "simul_ch1");

        wb(1'b0, 30'd5, 32'd0, 32'd0, 32'd0, 1'b1, "err_adr5");
        wr(30'd0, 32'hFFFF_FFFF, "write_status_ignored");
        rd(30'd0, 32'h0000_0000, 32'hFFFF_FFFF, "status_after_ro_write");
        rd(30'd3, 32'h0000_0000, TSM, "timestamp_read");

        // Reset during an access: no response.
        @(posedge clk48); #1;
        cyc = 1'b1; stb = 1'b1; we = 1'b0; adr = 30'd0; reset = 1'b0;
        cyc_wait(2);
        check("reset_abort_ack", 32'(ack), 32'd0);
        cyc = 1'b0; stb = 1'b0; reset = 1'b1;
        rd(30'd2, 32'h0000_0000, 32'hFFFF_FFFF, "ctrl_after_reset");
        cyc_wait(2);

        if (exp_q.size() != 0) begin
            n_cmp++; n_bad++;
            $display("FAIL leftover_expectations: got %0d pending want 0", exp_q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/usb_line_monitor.md
# usb_line_monitor

Multi-channel USB full-speed line monitor for the testbench wrappers. It samples the D+/D- pairs of up to 16 USB ports in the 48 MHz domain and decodes each into J/K/SE0/SE1 line states. Every deglitched state change is logged as a 32-bit event record in a shared FIFO, and per-channel bus-reset conditions are flagged. A Wishbone classic slave exposes status, events and control, so a cocotb bench can check line activity without parsing VCD dumps.

## Interface
- CHANNELS, 1: number of monitored D+/D- pairs, 1..16
- FIFO_DEPTH, 16: event FIFO entries, power of two, 4..256
- DEGLITCH, 2: cycles a decoded state must hold before it counts as a change, 1..15
- SE0_RESET_CYCLES, 120: consecutive SE0 cycles that flag a bus reset, 1..65535
- clk48  in  1  sole clock, 48 MHz
- reset  in  1  synchronous, active-low reset
- usb_d_p  in  CHANNELS  D+ per channel, asynchronous
- usb_d_n  in  CHANNELS  D- per channel, asynchronous
- wishbone_adr  in  30  word address; only bits [1:0] are decoded, and the upper bits must be zero
- wishbone_datwr  in  32  write data
- wishbone_datrd  out  32  read data
- wishbone_sel  in  4  byte select; ignored, all writes are full-word
- wishbone_cyc, wishbone_stb, wishbone_we  in  1  classic cycle controls
- wishbone_ack  out  1  cycle acknowledge
- wishbone_err  out  1  error acknowledge for undecoded addresses
- bus_reset  out  CHANNELS  level, high while SE0 has persisted for at least SE0_RESET_CYCLES

## Operation
- Per channel: a 2-flop synchronizer feeds the decoder. Line state {d_p,d_n} maps as 10=J, 01=K, 00=SE0, 11=SE1, with encoding J=2, K=1, SE0=0, SE1=3.
- Deglitch: the candidate state must stay identical for DEGLITCH cycles. It is then compared with the committed state. If they differ, the committed state updates and a change request raises.
- Event record layout:
  - [31:16] timestamp at commit
  - [15:8] channel index
  - [7:4] zero
  - [3:2] previous state
  - [1:0] new state
- Each channel has a one-deep pending register for event records.
  - A change arriving while that channel's pending register is full is dropped and sets OVERFLOW.
  - The arbiter pushes at most one pending record per cycle into the FIFO, lowest channel index first.
  - A push into a full FIFO drops the record and sets OVERFLOW.
- The SE0 run counter per channel saturates at SE0_RESET_CYCLES.
  - bus_reset[i] follows the counter level: high while the count equals SE0_RESET_CYCLES.
  - RST_STICKY[i] is set on the counter reaching SE0_RESET_CYCLES.
  - The counter clears on any committed non-SE0 state.
- Monitoring is gated by CTRL.ENABLE. While ENABLE=0, decoders still track line state but no records are generated and no flags are set.
- Register map (word addresses):
  - 0 STATUS (read-only): [31] OVERFLOW, [24:16] FIFO level, [15:0] RST_STICKY, with unused channel bits reading 0.
  - 1 EVENT (read-only): a read pops the FIFO and returns the head record. A read when empty returns 0xFFFF_FFFF and does not pop.
  - 2 CTRL (read/write): [0] ENABLE, reset value 0. Bit [1] CLEAR is write-one, self-clearing and reads 0. CLEAR flushes the FIFO and pending registers, zeros OVERFLOW, RST_STICKY and the timestamp, and leaves committed line states untouched.
  - 3 TIMESTAMP (read-only): [15:0] free-running counter, [31:16] zero.
- Writes to read-only registers are acknowledged and ignored. Address 0 is never erred.

## Timing
- Pin to committed state takes 2 + DEGLITCH cycles.
- A committed state is in the pending register on the next cycle. With no contention it is in the FIFO one cycle later.
- The timestamp is a 16-bit counter incremented every cycle and wrapping 0xFFFF to 0x0000. An event records the counter value in its commit cycle.
- Wishbone:
  - ack or err pulses for exactly one cycle, in the cycle after cyc&stb is first sampled high.
  - The strobe must drop after ack. A new access is accepted no earlier than the cycle after ack.
  - wishbone_datrd is valid with ack and holds 0 otherwise.
  - An EVENT pop takes effect with ack.
- Push and pop in the same cycle on a full FIFO succeeds with no overflow. The same case on an empty FIFO returns 0xFFFF_FFFF, and the pushed record remains.
- CLEAR coinciding with a push: CLEAR wins and the record is lost without setting OVERFLOW.
- Reset values:
  - wishbone_ack, wishbone_err and wishbone_datrd are 0, and bus_reset is all 0.
  - The FIFO is empty, all flags are 0 and the timestamp is 0.
  - Committed states are SE0 and the SE0 counters are 0.
- Asserting reset mid-transaction aborts it with no ack.

## Configuration
- USB_MON_TIMESTAMP_EN defined: the timestamp counter is built, event bits [31:16] carry it, and TIMESTAMP reads it.
- USB_MON_TIMESTAMP_EN undefined: no counter is built, event bits [31:16] are 0, and TIMESTAMP reads 0 with a normal ack.

## Structure
- Package usb_mon_pkg holds:
  - the line_state_t enum (SE0, K, J, SE1)
  - the event record struct
  - register address constants REG_STATUS, REG_EVENT, REG_CTRL, REG_TIMESTAMP
  - the CTRL bit indices
- Sub-module usb_mon_fifo is a synchronous FIFO with parametrised depth. It has push/pop/flush inputs, full/empty outputs and a level output of clog2(FIFO_DEPTH)+1 bits.
- Synchronizer, decode and deglitch logic sit in a generate loop over CHANNELS.

## Test plan
- Reset, then read STATUS -> 0x0000_0000. Read EVENT -> 0xFFFF_FFFF. bus_reset=0.
- ENABLE=1, CHANNELS=1, drive J then K, holding each 10 cycles -> EVENT reads previous state 0 (SE0) to new state 2 (J), then 2 to 1. Timestamps differ by 10.
- Drive a 1-cycle K glitch during J with DEGLITCH=2 -> no event, FIFO level stays 0.
- Hold SE0 for 120 cycles on channel 2 (CHANNELS=4) -> bus_reset[2] rises and STATUS[2]=1. Return to J -> bus_reset[2] falls and the sticky bit stays set until CLEAR.
- With FIFO_DEPTH=4, generate 6 changes without reading -> level is 4, STATUS[31]=1, and the first 4 records are popped in order.
- CHANNELS=2, both channels change in the same cycle -> channel 0's record is popped before channel 1's. An access to address 5 -> err pulse and no ack.
